pulse_sched: RTL and testbench

PULSE_SCHED -- requirements
Module: pulse_sched

---
 rtl/pulse_sched_pkg.sv | 14 +
 rtl/pulse_core.sv | 53 +++++
 rtl/pulse_sched.sv | 137 +++++++++++++
 tb/tb_pulse_sched.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pulse_sched_pkg.sv
// Shared state encoding and default field widths for the pulse scheduler.
package pulse_sched_pkg;

   localparam int unsigned CNT_W_DEF = 5;
   localparam int unsigned BST_W_DEF = 4;

   typedef logic [1:0] state_t;

   localparam state_t StIdle = 2'd0;
   localparam state_t StLoad = 2'd1;
   localparam state_t StRun  = 2'd2;
   localparam state_t StDone = 2'd3;

endpackage

// File: rtl/pulse_core.sv
// Phase counter and registered pulse output for one burst.
module pulse_core #(
   parameter int unsigned CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             run,
   input  logic             last,
   input  logic [CNT_W-1:0] high,
   input  logic [CNT_W-1:0] per,
   output logic             wrap,
   output logic             dout
);

   logic [CNT_W-1:0] phase_q, phase_d, phase_inc;
   logic             dout_q, dout_d;

   assign phase_inc = phase_q + CNT_W'(1);
   assign wrap      = run && (phase_q == per);
   assign dout      = dout_q;

   // Next phase and next output level; dout_d reflects the phase the next cycle will hold.
   always_comb begin
      phase_d = phase_q;
      dout_d  = 1'b0;
      if (start) begin
         phase_d = '0;
         dout_d  = (high != '0);
      end else if (run) begin
         if (wrap) begin
            phase_d = '0;
            // The final wrap hands over to DONE, where the output is forced low.
            dout_d  = !last && (high != '0);
         end else begin
            phase_d = phase_inc;
            dout_d  = (phase_inc < high);
         end
      end
   end

   // Phase and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase_q <= '0;
         dout_q  <= 1'b0;
      end else begin
         phase_q <= phase_d;
         dout_q  <= dout_d;
      end
   end

endmodule

// File: rtl/pulse_sched.sv
// Two-requester round-robin burst pulse scheduler.
module pulse_sched
   import pulse_sched_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF,
   parameter int unsigned BST_W = BST_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req,
   input  logic [CNT_W-1:0] high0,
   input  logic [CNT_W-1:0] high1,
   input  logic [CNT_W-1:0] per0,
   input  logic [CNT_W-1:0] per1,
   input  logic [BST_W-1:0] bst0,
   input  logic [BST_W-1:0] bst1,
   output logic [1:0]       gnt,
   output logic             busy,
   output logic [1:0]       done,
   output logic             dout
);

   state_t           state_q, state_d;
   logic [1:0]       gnt_q, gnt_d;
   logic [1:0]       done_q, done_d;
   logic             gidx_q, gidx_d;
   logic             rr_q, rr_d;      // 1: requester 1 wins a tie
   logic [CNT_W-1:0] high_q, high_d;
   logic [CNT_W-1:0] per_q, per_d;
   logic [BST_W-1:0] bst_q, bst_d;
   logic [BST_W-1:0] bcnt_q, bcnt_d;
   logic             win;
   logic             req_g;
   logic             wrap;

   assign req_g = req[gidx_q];
   assign gnt   = gnt_q;
   assign done  = done_q;
   assign busy  = (state_q != StIdle);

   // Arbitration, FSM sequencing, burst counting and config capture.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      done_d  = '0;
      gidx_d  = gidx_q;
      rr_d    = rr_q;
      high_d  = high_q;
      per_d   = per_q;
      bst_d   = bst_q;
      bcnt_d  = bcnt_q;
      win     = 1'b0;
      case (state_q)
         StIdle: begin
            if (|req) begin
               win     = (req == 2'b11) ? rr_q : req[1];
               gidx_d  = win;
               gnt_d   = win ? 2'b10 : 2'b01;
               high_d  = win ? high1 : high0;
               per_d   = win ? per1 : per0;
               bst_d   = win ? bst1 : bst0;
               state_d = StLoad;
            end
         end
         StLoad: begin
            if (!req_g) begin
               state_d = StIdle;
               gnt_d   = '0;
               rr_d    = ~gidx_q;
            end else begin
               bcnt_d  = bst_q;
               state_d = StRun;
            end
         end
         StRun: begin
            if (!req_g) begin
               state_d = StIdle;
               gnt_d   = '0;
               rr_d    = ~gidx_q;
            end else if (wrap) begin
               if (bcnt_q == '0) begin
                  state_d = StDone;
                  done_d  = gnt_q;
               end else begin
                  bcnt_d = bcnt_q - BST_W'(1);
               end
            end
         end
         StDone: begin
            state_d = StIdle;
            gnt_d   = '0;
            rr_d    = ~gidx_q;
         end
         default: state_d = StIdle;
      endcase
   end

   // Scheduler state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         gnt_q   <= '0;
         done_q  <= '0;
         gidx_q  <= 1'b0;
         rr_q    <= 1'b0;
         high_q  <= '0;
         per_q   <= '0;
         bst_q   <= '0;
         bcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         gidx_q  <= gidx_d;
         rr_q    <= rr_d;
         high_q  <= high_d;
         per_q   <= per_d;
         bst_q   <= bst_d;
         bcnt_q  <= bcnt_d;
      end
   end

   pulse_core #(
      .CNT_W (CNT_W)
   ) u_core (
      .clk   (clk),
      .reset (reset),
      .start ((state_q == StLoad) && req_g),
      .run   ((state_q == StRun) && req_g),
      .last  (bcnt_q == '0),
      .high  (high_q),
      .per   (per_q),
      .wrap  (wrap),
      .dout  (dout)
   );

endmodule

// File: tb/tb_pulse_sched.sv
// Directed self-checking bench for pulse_sched.
module tb_pulse_sched;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] req;
   logic [4:0] high0, high1, per0, per1;
   logic [3:0] bst0, bst1;
   logic [1:0] gnt;
   logic       busy;
   logic [1:0] done;
   logic       dout;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pulse_sched dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .high0 (high0),
      .high1 (high1),
      .per0  (per0),
      .per1  (per1),
      .bst0  (bst0),
      .bst1  (bst1),
      .gnt   (gnt),
      .busy  (busy),
      .done  (done),
      .dout  (dout)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts in the LOAD cycle; returns in the DONE cycle (or on cycle budget expiry).
   task automatic measure(output int busy_n, output int high_n, output logic [1:0] done_v,
                          output logic dout_at_done, output logic first_dout,
                          output logic timeout);
      busy_n = 0; high_n = 0; done_v = 2'b00; dout_at_done = 1'b0;
      first_dout = 1'b0; timeout = 1'b1;
      for (int c = 0; c < 200; c++) begin
         if (c == 1) first_dout = dout;
         if (busy) busy_n++;
         if (dout) high_n++;
         if (done != 2'b00) begin
            done_v = done; dout_at_done = dout; timeout = 1'b0;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; req = 2'b00;
      high0 = '0; high1 = '0; per0 = '0; per1 = '0; bst0 = '0; bst1 = '0;
      #3;
      checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 2'b00) begin failures++; $display("FAIL reset_done got=%b exp=00", done); end
      checks++; if (dout !== 1'b0) begin failures++; $display("FAIL reset_dout got=%b exp=0", dout); end
   endtask

   task automatic test_round_robin();
      int b, h; logic [1:0] dv; logic dd, fd, to;
      high0 = 5'd2; per0 = 5'd3; bst0 = 4'd1;
      high1 = 5'd2; per1 = 5'd3; bst1 = 4'd1;
      req = 2'b11;
      tick(); tick();
      reset = 1'b1;
      tick();
      checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL rr_first_gnt got=%b exp=01", gnt); end
      measure(b, h, dv, dd, fd, to);
      checks++; if (to !== 1'b0) begin failures++; $display("FAIL rr0_timeout got=%b exp=0", to); end
      checks++; if (b != 10) begin failures++; $display("FAIL rr0_busy got=%0d exp=10", b); end
      checks++; if (h != 4) begin failures++; $display("FAIL rr0_highs got=%0d exp=4", h); end
      checks++; if (dv !== 2'b01) begin failures++; $display("FAIL rr0_done got=%b exp=01", dv); end
      tick();
      checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL rr_gap_gnt got=%b exp=00", gnt); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_gap_busy got=%b exp=0", busy); end
      tick();
      checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL rr_second_gnt got=%b exp=10", gnt); end
      measure(b, h, dv, dd, fd, to);
      checks++; if (b != 10) begin failures++; $display("FAIL rr1_busy got=%0d exp=10", b); end
      checks++; if (h != 4) begin failures++; $display("FAIL rr1_highs got=%0d exp=4", h); end
      checks++; if (dv !== 2'b10) begin failures++; $display("FAIL rr1_done got=%b exp=10", dv); end
      req = 2'b00;
      tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_end_busy got=%b exp=0", busy); end
   endtask

   task automatic test_single();
      int b, h; logic [1:0] dv; logic dd, fd, to;
      high0 = 5'd5; per0 = 5'd16; bst0 = 4'd0;
      req = 2'b01;
      tick();
      checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL single_gnt got=%b exp=01", gnt); end
      checks++; if (dout !== 1'b0) begin failures++; $display("FAIL single_load_dout got=%b exp=0", dout); end
      measure(b, h, dv, dd, fd, to);
      checks++; if (to !== 1'b0) begin failures++; $display("FAIL single_timeout got=%b exp=0", to); end
      checks++; if (fd !== 1'b1) begin failures++; $display("FAIL single_first_dout got=%b exp=1", fd); end
      checks++; if (b != 19) begin failures++; $display("FAIL single_busy got=%0d exp=19", b); end
      checks++; if (h != 5) begin failures++; $display("FAIL single_highs got=%0d exp=5", h); end
      checks++; if (dv !== 2'b01) begin failures++; $display("FAIL single_done got=%b exp=01", dv); end
      checks++; if (dd !== 1'b0) begin failures++; $display("FAIL single_done_dout got=%b exp=0", dd); end
      req = 2'b00;
      tick();
      checks++; if (done !== 2'b00) begin failures++; $display("FAIL single_done_width got=%b exp=00", done); end
      checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL single_end_gnt got=%b exp=00", gnt); end
   endtask

   task automatic test_high_zero();
      int b, h; logic [1:0] dv; logic dd, fd, to;
      high0 = 5'd0; per0 = 5'd3; bst0 = 4'd2;
      req = 2'b01;
      tick();
      measure(b, h, dv, dd, fd, to);
      checks++; if (b != 14) begin failures++; $display("FAIL hz_busy got=%0d exp=14", b); end
      checks++; if (h != 0) begin failures++; $display("FAIL hz_highs got=%0d exp=0", h); end
      checks++; if (dv !== 2'b01) begin failures++; $display("FAIL hz_done got=%b exp=01", dv); end
      req = 2'b00;
      tick();
   endtask

   task automatic test_high_over();
      int b, h; logic [1:0] dv; logic dd, fd, to;
      high1 = 5'd20; per1 = 5'd7; bst1 = 4'd0;
      req = 2'b10;
      tick();
      checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL ho_gnt got=%b exp=10", gnt); end
      measure(b, h, dv, dd, fd, to);
      checks++; if (b != 10) begin failures++; $display("FAIL ho_busy got=%0d exp=10", b); end
      checks++; if (h != 8) begin failures++; $display("FAIL ho_highs got=%0d exp=8", h); end
      checks++; if (dv !== 2'b10) begin failures++; $display("FAIL ho_done got=%b exp=10", dv); end
      req = 2'b00;
      tick();
   endtask

   task automatic test_abort();
      int b, h; logic [1:0] dv; logic dd, fd, to;
      high0 = 5'd5; per0 = 5'd3; bst0 = 4'd3;
      high1 = 5'd1; per1 = 5'd1; bst1 = 4'd0;
      req = 2'b11;
      tick();
      checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL ab_gnt got=%b exp=01", gnt); end
      tick(); tick(); tick(); tick();
      checks++; if (dout !== 1'b1) begin failures++; $display("FAIL ab_run4_dout got=%b exp=1", dout); end
      req = 2'b10;
      tick();
      checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL ab_gnt_clr got=%b exp=00", gnt); end
      checks++; if (dout !== 1'b0) begin failures++; $display("FAIL ab_dout got=%b exp=0", dout); end
      checks++; if (done !== 2'b00) begin failures++; $display("FAIL ab_done got=%b exp=00", done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ab_busy got=%b exp=0", busy); end
      tick();
      checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL ab_next_gnt got=%b exp=10", gnt); end
      measure(b, h, dv, dd, fd, to);
      checks++; if (b != 4) begin failures++; $display("FAIL ab1_busy got=%0d exp=4", b); end
      checks++; if (h != 1) begin failures++; $display("FAIL ab1_highs got=%0d exp=1", h); end
      checks++; if (dv !== 2'b10) begin failures++; $display("FAIL ab1_done got=%b exp=10", dv); end
      req = 2'b00;
      tick();
   endtask

   task automatic test_reset_mid_run();
      int b, h; logic [1:0] dv; logic dd, fd, to;
      // Serve requester 0 so a tie would favour requester 1 without a pointer reset.
      high0 = 5'd1; per0 = 5'd1; bst0 = 4'd0;
      req = 2'b01;
      tick();
      measure(b, h, dv, dd, fd, to);
      checks++; if (dv !== 2'b01) begin failures++; $display("FAIL rm_pre_done got=%b exp=01", dv); end
      req = 2'b00;
      tick();
      high1 = 5'd20; per1 = 5'd7; bst1 = 4'd3;
      req = 2'b10;
      tick(); tick(); tick();
      checks++; if (dout !== 1'b1) begin failures++; $display("FAIL rm_run_dout got=%b exp=1", dout); end
      reset = 1'b0;
      #2;
      checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL rm_gnt got=%b exp=00", gnt); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rm_busy got=%b exp=0", busy); end
      checks++; if (dout !== 1'b0) begin failures++; $display("FAIL rm_dout got=%b exp=0", dout); end
      checks++; if (done !== 2'b00) begin failures++; $display("FAIL rm_done got=%b exp=00", done); end
      #3;
      reset = 1'b1;
      req = 2'b11;
      tick();
      checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL rm_post_gnt got=%b exp=01", gnt); end
      checks++; if (done !== 2'b00) begin failures++; $display("FAIL rm_post_done got=%b exp=00", done); end
      req = 2'b00;
      tick();
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_high_zero();
      test_high_over();
      test_abort();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
